pipe_stage_reg: RTL

Parametrised pipeline stage register that replaces the fixed, per-signal inter-stage latches (fetch/decode, decode/execute, execute/memory, memory/writeback) with one generic block. It carries a packed stage word of configurable width, a valid bit and an optional one-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. It keeps the existing global-advance (hit) and stall gating and the flush-to-bubble behaviour, and adds valid/ready handshaking plus saturating stall/flush/bubble performance counters.

---
 rtl/cpu_types_pkg.sv | 59 +++++
 rtl/sat_counter.sv | 38 +++
 rtl/pipe_stage_reg.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared stage-word types and helpers for the generic pipeline stage register.
package cpu_types_pkg;

  localparam int PSR_OCC_W = 2;

  typedef enum logic [1:0] {
    PSR_HOLD  = 2'd0,
    PSR_FLUSH = 2'd1,
    PSR_ADV   = 2'd2
  } psr_upd_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fd_word_t;

  typedef struct packed {
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        halt;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        atomic;
  } de_word_t;

  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] rdat2;
    logic [4:0]  wsel;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        halt;
    logic        atomic;
  } em_word_t;

  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] dload;
    logic [4:0]  wsel;
    logic        regwrite;
    logic        memtoreg;
    logic        halt;
  } mw_word_t;

  function automatic logic [PSR_OCC_W-1:0] psr_occ(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = {W{1'b0}};
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1'b1);
    end else begin
      q_d = q_q;
    end
  end

  // count register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q_q <= {W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, optional skid entry,
// global-advance/stall gating, flush-to-bubble and saturating perf counters.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int DW    = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 en,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 clr_cnt,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  input  logic                 out_ready,
  output logic [PSR_OCC_W-1:0] occ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic                 adv_s;
  logic                 accept_s;
  logic                 consume_s;
  logic                 in_ready_s;
  psr_upd_e             upd_s;

  logic                 main_v_q;
  logic                 main_v_d;
  logic [DW-1:0]        main_data_q;
  logic [DW-1:0]        main_data_d;
  logic [PSR_OCC_W-1:0] occ_q;

  logic                 skid_v_s;
  logic                 skid_v_nx_s;
  logic [DW-1:0]        skid_data_s;

  assign adv_s     = en & ~stall;
  assign accept_s  = in_valid & in_ready_s & adv_s;
  assign consume_s = main_v_q & out_ready & adv_s;

  // update class: flush outranks advance, otherwise hold
  always_comb begin
    upd_s = PSR_HOLD;
    if (flush) begin
      upd_s = PSR_FLUSH;
    end else if (adv_s) begin
      upd_s = PSR_ADV;
    end else begin
      upd_s = PSR_HOLD;
    end
  end

  // head entry next state; data is kept zero whenever the head is empty
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    case (upd_s)
      PSR_FLUSH: begin
        main_v_d    = 1'b0;
        main_data_d = {DW{1'b0}};
      end
      PSR_ADV: begin
        if (consume_s && accept_s) begin
          main_v_d    = 1'b1;
          main_data_d = skid_v_s ? skid_data_s : in_data;
        end else if (consume_s) begin
          if (skid_v_s) begin
            main_v_d    = 1'b1;
            main_data_d = skid_data_s;
          end else begin
            main_v_d    = 1'b0;
            main_data_d = {DW{1'b0}};
          end
        end else if (accept_s && !main_v_q) begin
          main_v_d    = 1'b1;
          main_data_d = in_data;
        end else begin
          main_v_d    = main_v_q;
          main_data_d = main_data_q;
        end
      end
      default: begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
      end
    endcase
  end

  generate
    if (SKID != 0) begin : gen_skid
      logic          skid_v_q;
      logic          skid_v_d;
      logic [DW-1:0] skid_data_q;
      logic [DW-1:0] skid_data_d;

      // skid entry next state; it only fills while the head is occupied
      always_comb begin
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        case (upd_s)
          PSR_FLUSH: begin
            skid_v_d    = 1'b0;
            skid_data_d = {DW{1'b0}};
          end
          PSR_ADV: begin
            if (consume_s && accept_s) begin
              skid_v_d    = skid_v_q;
              skid_data_d = skid_v_q ? in_data : skid_data_q;
            end else if (consume_s) begin
              skid_v_d    = 1'b0;
              skid_data_d = skid_data_q;
            end else if (accept_s && main_v_q) begin
              skid_v_d    = 1'b1;
              skid_data_d = in_data;
            end else begin
              skid_v_d    = skid_v_q;
              skid_data_d = skid_data_q;
            end
          end
          default: begin
            skid_v_d    = skid_v_q;
            skid_data_d = skid_data_q;
          end
        endcase
      end

      // skid registers
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_v_q    <= 1'b0;
          skid_data_q <= {DW{1'b0}};
        end else begin
          skid_v_q    <= skid_v_d;
          skid_data_q <= skid_data_d;
        end
      end

      assign skid_v_s    = skid_v_q;
      assign skid_v_nx_s = skid_v_d;
      assign skid_data_s = skid_data_q;
      assign in_ready_s  = ~skid_v_q;
    end else begin : gen_noskid
      assign skid_v_s    = 1'b0;
      assign skid_v_nx_s = 1'b0;
      assign skid_data_s = {DW{1'b0}};
      assign in_ready_s  = adv_s & (~main_v_q | out_ready);
    end
  endgenerate

  // head and occupancy registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_v_q    <= 1'b0;
      main_data_q <= {DW{1'b0}};
      occ_q       <= {PSR_OCC_W{1'b0}};
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      occ_q       <= psr_occ(main_v_d, skid_v_nx_s);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (clr_cnt),
    .inc  (en & stall),
    .q    (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (clr_cnt),
    .inc  (flush & (occ_q != {PSR_OCC_W{1'b0}})),
    .q    (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (clr_cnt),
    .inc  (adv_s & out_ready & ~main_v_q),
    .q    (bubble_cnt)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign occ       = occ_q;

endmodule
